// File: rtl/mnist_ctrl_pkg.sv
// Shared definitions for the MNIST button command path: controller FSM
// states, digit width and seven-segment display-mode encodings.
package mnist_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } ctrl_state_e;

  localparam int DIGIT_W = 4;

  localparam logic DISP_IDX    = 1'b0;
  localparam logic DISP_RESULT = 1'b1;

endpackage

// File: rtl/button_cmd_ctrl_if.sv
// Bundle between the debounced buttons / inference core / display driver
// (master side) and the button command controller (slave side).
interface button_cmd_ctrl_if #(
  parameter int IDX_W = 4
);
  import mnist_ctrl_pkg::*;

  logic               btnu_pulse;
  logic               btnc_pulse;
  logic               btnr_pulse;
  logic               infer_done;
  logic [DIGIT_W-1:0] infer_digit;
  logic [IDX_W-1:0]   img_idx;
  logic               infer_start;
  logic               busy;
  logic [DIGIT_W-1:0] result_digit;
  logic               result_valid;
  logic               disp_mode;
  logic               err;

  modport master (
    output btnu_pulse, btnc_pulse, btnr_pulse, infer_done, infer_digit,
    input  img_idx, infer_start, busy, result_digit, result_valid,
           disp_mode, err
  );

  modport slave (
    input  btnu_pulse, btnc_pulse, btnr_pulse, infer_done, infer_digit,
    output img_idx, infer_start, busy, result_digit, result_valid,
           disp_mode, err
  );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-N up-counter with enable; wraps from N-1 back to 0.
module wrap_counter #(
  parameter int N = 10,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  // Advance on enable, wrapping at the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/button_cmd_ctrl.sv
// Button command controller: turns debounced btnu/btnc/btnr pulses into
// image selection, an inference start/done handshake, result latching and
// display-mode control.
// Optional build macro INFER_TIMEOUT_EN adds a BUSY watchdog that aborts
// a hung inference after TIMEOUT_CYCLES and raises a sticky err flag.
module button_cmd_ctrl
  import mnist_ctrl_pkg::*;
#(
  parameter int NUM_IMAGES     = 10,
  parameter int IDX_W          = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  button_cmd_ctrl_if.slave bus
);

  // Reject configurations where the index cannot hold every image or the
  // watchdog limit is meaningless.
  if ((2 ** IDX_W) < NUM_IMAGES || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("button_cmd_ctrl: invalid NUM_IMAGES/IDX_W/TIMEOUT_CYCLES");
  end

  ctrl_state_e        state_q, state_d;
  logic               idx_adv;
  logic [IDX_W-1:0]   idx_q;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic               valid_q, valid_d;
  logic               disp_q, disp_d;

`ifdef INFER_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Image index: only advanced by btnu while no inference is in flight.
  wrap_counter #(
    .N (NUM_IMAGES),
    .W (IDX_W)
  ) u_idx_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (idx_adv),
    .count (idx_q)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, index advance, result/display/error next values.
  always_comb begin
    state_d = state_q;
    idx_adv = 1'b0;
    digit_d = digit_q;
    valid_d = valid_q;
`ifdef INFER_TIMEOUT_EN
    err_d   = err_q;
    cnt_d   = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        // btnu and btnc together: index advances on this edge, so the
        // launched inference already sees the new image.
        if (bus.btnu_pulse) begin
          idx_adv = 1'b1;
          valid_d = 1'b0;
        end
        if (bus.btnc_pulse) begin
          state_d = START;
`ifdef INFER_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      START: begin
        state_d = BUSY;
      end
      BUSY: begin
        // A done arriving together with the watchdog expiry still counts.
        if (bus.infer_done) begin
          state_d = IDLE;
          digit_d = bus.infer_digit;
          valid_d = 1'b1;
        end
`ifdef INFER_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          valid_d = 1'b0;
          err_d   = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef INFER_TIMEOUT_EN
    // Watchdog restarts on every launch and counts BUSY cycles.
    if (state_d == START) begin
      cnt_d = '0;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q + 1'b1;
    end
`endif

    // Forced display changes take priority over the btnr toggle.
    if (state_q == BUSY && bus.infer_done) begin
      disp_d = DISP_RESULT;
    end else if (state_q == IDLE && bus.btnu_pulse) begin
      disp_d = DISP_IDX;
    end else if (bus.btnr_pulse) begin
      disp_d = ~disp_q;
    end else begin
      disp_d = disp_q;
    end
  end

  // Result, display-mode and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
      valid_q <= 1'b0;
      disp_q  <= DISP_IDX;
`ifdef INFER_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      digit_q <= digit_d;
      valid_q <= valid_d;
      disp_q  <= disp_d;
`ifdef INFER_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.img_idx      = idx_q;
  assign bus.infer_start  = (state_q == START);
  assign bus.busy         = (state_q != IDLE);
  assign bus.result_digit = digit_q;
  assign bus.result_valid = valid_q;
  assign bus.disp_mode    = disp_q;
`ifdef INFER_TIMEOUT_EN
  assign bus.err          = err_q;
`else
  assign bus.err          = 1'b0;
`endif

endmodule

// File: tb/tb_button_cmd_ctrl.sv
// Testbench for button_cmd_ctrl: directed scenarios plus randomized pulses,
// all checked against a transaction-level reference model.
module tb_button_cmd_ctrl;

  localparam int N  = 10;
  localparam int IW = 4;
  localparam int TO = 50;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  button_cmd_ctrl_if #(.IDX_W(IW)) bif ();

  button_cmd_ctrl #(
    .NUM_IMAGES     (N),
    .IDX_W          (IW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: m_age < 0 means no inference in flight, 0 means the
  // start strobe is showing, k >= 1 means the k-th cycle of waiting.
  int m_idx, m_age, m_digit;
  bit m_valid, m_disp, m_err;

  function automatic logic [12:0] model_vec();
    return {4'(m_idx), (m_age == 0), (m_age >= 0), 4'(m_digit),
            m_valid, m_disp, m_err};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {bif.img_idx, bif.infer_start, bif.busy, bif.result_digit,
            bif.result_valid, bif.disp_mode, bif.err};
  endfunction

  task automatic model_reset();
    m_idx = 0; m_age = -1; m_digit = 0;
    m_valid = 0; m_disp = 0; m_err = 0;
  endtask

  task automatic model_step(input bit u, c, r, d, input int dig);
    if (m_age < 0) begin
      if (u) begin
        m_idx = (m_idx + 1) % N; m_valid = 0; m_disp = 0;
      end else if (r) begin
        m_disp = !m_disp;
      end
      if (c) begin
        m_age = 0; m_err = 0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
      if (r) m_disp = !m_disp;
    end else if (d) begin
      m_digit = dig; m_valid = 1; m_disp = 1; m_age = -1;
    end else begin
      if (r) m_disp = !m_disp;
`ifdef INFER_TIMEOUT_EN
      if (m_age == TO) begin
        m_age = -1; m_valid = 0; m_err = 1;
      end else begin
        m_age++;
      end
`else
      m_age++;
`endif
    end
  endtask

  // Present inputs for one clock, advance the model at the edge, sample
  // outputs 1 time unit after the edge and drop the pulses again.
  task automatic cycle(input bit u, c, r, d, input int dig);
    bif.btnu_pulse  = u;
    bif.btnc_pulse  = c;
    bif.btnr_pulse  = r;
    bif.infer_done  = d;
    bif.infer_digit = 4'(dig);
    @(posedge clk);
    model_step(u, c, r, d, dig);
    #1;
    bif.btnu_pulse  = 1'b0;
    bif.btnc_pulse  = 1'b0;
    bif.btnr_pulse  = 1'b0;
    bif.infer_done  = 1'b0;
    bif.infer_digit = '0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_cmp++;
    if (dut_vec() !== 13'd0) begin
      n_bad++; $display("FAIL reset_state: got %h expected %h", dut_vec(), 13'd0);
    end
    model_reset();
    rst_n = 1'b1;
    cycle(0, 0, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_bad++; $display("FAIL reset_release: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_index_wrap();
    for (int i = 0; i < 12; i++) begin
      cycle(1, 0, 0, 0, 0);
      n_cmp++;
      if (bif.img_idx !== IW'((i + 1) % N)) begin
        n_bad++; $display("FAIL idx_wrap[%0d]: got %0d expected %0d", i, bif.img_idx, (i + 1) % N);
      end
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      n_cmp++;
      if (bif.busy !== 1'b0) begin
        n_bad++; $display("FAIL idx_busy[%0d]: got %b expected 0", i, bif.busy);
      end
    end
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_bad++; $display("FAIL idx_state: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_inference();
    int starts;
    cycle(1, 0, 0, 0, 0);
    n_cmp++;
    if (bif.img_idx !== 4'd3 || bif.infer_start !== 1'b0) begin
      n_bad++; $display("FAIL inf_pre: got idx %0d start %b expected 3 0", bif.img_idx, bif.infer_start);
    end
    cycle(0, 1, 0, 0, 0);
    n_cmp++;
    if (bif.infer_start !== 1'b1 || bif.busy !== 1'b1) begin
      n_bad++; $display("FAIL inf_start: got start %b busy %b expected 1 1", bif.infer_start, bif.busy);
    end
    starts = 0;
    for (int k = 0; k < 19; k++) begin
      cycle(0, 0, 0, 0, 0);
      if (bif.infer_start) starts++;
      n_cmp++;
      if (bif.busy !== 1'b1) begin
        n_bad++; $display("FAIL inf_busy[%0d]: got %b expected 1", k, bif.busy);
      end
    end
    n_cmp++;
    if (starts != 0) begin
      n_bad++; $display("FAIL inf_start_width: got %0d extra strobes expected 0", starts);
    end
    cycle(0, 0, 0, 1, 7);
    n_cmp++;
    if ({bif.result_digit, bif.result_valid, bif.disp_mode, bif.busy} !== {4'd7, 1'b1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL inf_result: got digit %0d valid %b disp %b busy %b expected 7 1 1 0",
                        bif.result_digit, bif.result_valid, bif.disp_mode, bif.busy);
    end
  endtask

  task automatic test_busy_ignore();
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    n_cmp++;
    if (bif.img_idx !== 4'd3) begin
      n_bad++; $display("FAIL busy_btnu: got idx %0d expected 3", bif.img_idx);
    end
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    n_cmp++;
    if (bif.infer_start !== 1'b0) begin
      n_bad++; $display("FAIL busy_btnc: got start %b expected 0", bif.infer_start);
    end
    cycle(0, 0, 1, 0, 0);
    n_cmp++;
    if (bif.disp_mode !== 1'b0 || bif.busy !== 1'b1) begin
      n_bad++; $display("FAIL busy_btnr: got disp %b busy %b expected 0 1", bif.disp_mode, bif.busy);
    end
    cycle(0, 0, 0, 1, $urandom_range(0, 9));
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_bad++; $display("FAIL busy_done: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_simultaneous();
    int d1;
    d1 = $urandom_range(0, 9);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0);
    n_cmp++;
    if (bif.img_idx !== 4'd9) begin
      n_bad++; $display("FAIL sim_idx9: got %0d expected 9", bif.img_idx);
    end
    cycle(1, 1, 0, 0, 0);
    n_cmp++;
    if ({bif.img_idx, bif.infer_start, bif.result_valid, bif.disp_mode} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL sim_u_c: got idx %0d start %b valid %b disp %b expected 0 1 0 0",
                        bif.img_idx, bif.infer_start, bif.result_valid, bif.disp_mode);
    end
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 1, d1);
    n_cmp++;
    if (bif.disp_mode !== 1'b1 || bif.result_digit !== 4'(d1)) begin
      n_bad++; $display("FAIL sim_r_done: got disp %b digit %0d expected 1 %0d", bif.disp_mode, bif.result_digit, d1);
    end
    cycle(0, 0, 0, 1, (d1 + 1) % 10);
    n_cmp++;
    if (bif.result_digit !== 4'(d1) || bif.busy !== 1'b0) begin
      n_bad++; $display("FAIL sim_stray_done: got digit %0d busy %b expected %0d 0", bif.result_digit, bif.busy, d1);
    end
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    n_cmp++;
    if (bif.disp_mode !== 1'b0 || bif.img_idx !== 4'd1) begin
      n_bad++; $display("FAIL sim_u_r: got disp %b idx %0d expected 0 1", bif.disp_mode, bif.img_idx);
    end
  endtask

  task automatic test_reset_mid();
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec() !== 13'd0) begin
      n_bad++; $display("FAIL rstmid_async: got %h expected %h", dut_vec(), 13'd0);
    end
    #2 rst_n = 1'b1;
    cycle(0, 0, 0, 1, 5);
    n_cmp++;
    if (dut_vec() !== 13'd0) begin
      n_bad++; $display("FAIL rstmid_late_done: got %h expected %h", dut_vec(), 13'd0);
    end
  endtask

  task automatic test_random();
    bit u, c, r, d;
    for (int i = 0; i < 600; i++) begin
      u = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 9) == 0);
      d = ($urandom_range(0, 5) == 0);
      cycle(u, c, r, d, $urandom_range(0, 9));
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
  endtask

`ifdef INFER_TIMEOUT_EN
  task automatic test_timeout();
    if (bif.busy) cycle(0, 0, 0, 1, 0);
    if (bif.busy) cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    for (int k = 1; k <= TO + 1; k++) begin
      cycle(0, 0, 0, 0, 0);
      n_cmp++;
      if (k <= TO && (bif.busy !== 1'b1 || bif.err !== 1'b0)) begin
        n_bad++; $display("FAIL to_wait[%0d]: got busy %b err %b expected 1 0", k, bif.busy, bif.err);
      end else if (k == TO + 1 && {bif.busy, bif.err, bif.result_valid} !== 3'b010) begin
        n_bad++; $display("FAIL to_expire: got busy %b err %b valid %b expected 0 1 0",
                          bif.busy, bif.err, bif.result_valid);
      end
    end
    cycle(0, 1, 0, 0, 0);
    n_cmp++;
    if (bif.err !== 1'b0 || bif.infer_start !== 1'b1) begin
      n_bad++; $display("FAIL to_clear: got err %b start %b expected 0 1", bif.err, bif.infer_start);
    end
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 4);
  endtask
`endif

  initial begin
    bif.btnu_pulse  = 1'b0;
    bif.btnc_pulse  = 1'b0;
    bif.btnr_pulse  = 1'b0;
    bif.infer_done  = 1'b0;
    bif.infer_digit = '0;
    model_reset();
    test_reset();
    test_index_wrap();
    test_inference();
    test_busy_ignore();
    test_simultaneous();
    test_reset_mid();
`ifdef INFER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "time limit");
  end

endmodule
